// File: rtl/ucode_sequencer.sv
// ucode_sequencer: T-state counter and instruction register for the microcoded CPU.
// Supplies {instr, T-2} to the decode ROM and returns the active microinstruction:
// T0/T1 are hardwired fetch words, T2..T7 come straight from the ROM.
// Optional feature macro: UCODE_EARLY_END_EN (an all-zero ROM word at T>=2 ends the instruction).
module ucode_sequencer #(
   parameter logic [15:0] FETCH0_UINSTR = 16'h4800,
   parameter logic [15:0] FETCH1_UINSTR = 16'h1D00,
   parameter int unsigned II_BIT        = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        step,
   input  logic [15:0] bus_in,
   input  logic [15:0] dec_uinstr,
   output logic [15:0] dec_instr,
   output logic [2:0]  dec_T,
   output logic [15:0] uinstr,
   output logic [2:0]  T,
   output logic        instr_done
);

   typedef enum logic [2:0] {
      T0_FETCH_ADDR  = 3'd0,
      T1_FETCH_INSTR = 3'd1,
      T2_EXEC        = 3'd2,
      T3_EXEC        = 3'd3,
      T4_EXEC        = 3'd4,
      T5_EXEC        = 3'd5,
      T6_EXEC        = 3'd6,
      T7_EXEC        = 3'd7
   } tstate_e;

   tstate_e     r_state;
   tstate_e     w_state_nxt;
   logic [15:0] r_instr;
   logic [15:0] w_instr_nxt;
   logic [15:0] w_uinstr;
   logic        w_end_of_instr;
   logic        w_exec;

   // State register and instruction register; reset abandons any instruction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= T0_FETCH_ADDR;
         r_instr <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_instr <= w_instr_nxt;
      end
   end

   // Microinstruction select, end-of-instruction detect and next-state/IR load.
   always_comb begin
      w_uinstr       = dec_uinstr;
      w_state_nxt    = r_state;
      w_instr_nxt    = r_instr;
      w_exec         = (r_state >= T2_EXEC);
      w_end_of_instr = (r_state == T7_EXEC);

      case (r_state)
         T0_FETCH_ADDR:  w_uinstr = FETCH0_UINSTR;
         T1_FETCH_INSTR: w_uinstr = FETCH1_UINSTR;
         default:        w_uinstr = dec_uinstr;
      endcase

`ifdef UCODE_EARLY_END_EN
      // A zero ROM word is still issued on uinstr, but it also terminates the instruction.
      if (w_exec && (dec_uinstr == '0)) begin
         w_end_of_instr = 1'b1;
      end
`endif

      if (step) begin
         if (w_uinstr[II_BIT]) begin
            w_instr_nxt = bus_in;
         end
         if (w_end_of_instr) begin
            w_state_nxt = T0_FETCH_ADDR;
         end else begin
            w_state_nxt = tstate_e'(r_state + 3'd1);
         end
      end
   end

   assign uinstr     = w_uinstr;
   assign T          = r_state;
   assign dec_instr  = r_instr;
   assign dec_T      = w_exec ? (r_state - 3'd2) : '0;
   assign instr_done = step & w_end_of_instr;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer; expectations follow UCODE_EARLY_END_EN if defined.
module tb_ucode_sequencer;

   logic        clk;
   logic        rst_n;
   logic        step;
   logic [15:0] bus_in;
   logic [15:0] dec_uinstr;
   logic [15:0] dec_instr;
   logic [2:0]  dec_T;
   logic [15:0] uinstr;
   logic [2:0]  T;
   logic        instr_done;

   int checks = 0;
   int errors = 0;

   ucode_sequencer #(
      .FETCH0_UINSTR (16'h4800),
      .FETCH1_UINSTR (16'h1D00),
      .II_BIT        (12)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .step       (step),
      .bus_in     (bus_in),
      .dec_uinstr (dec_uinstr),
      .dec_instr  (dec_instr),
      .dec_T      (dec_T),
      .uinstr     (uinstr),
      .T          (T),
      .instr_done (instr_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n      = 1'b0;
      step       = 1'b0;
      bus_in     = 16'h0000;
      dec_uinstr = 16'h0000;

      // Reset values before any clock edge.
      #3;
      chk("rst_T", {13'd0, T}, 16'd0);
      chk("rst_instr", dec_instr, 16'h0000);
      chk("rst_uinstr", uinstr, 16'h4800);
      chk("rst_decT", {13'd0, dec_T}, 16'd0);
      chk("rst_done", {15'd0, instr_done}, 16'd0);

      // Release reset between edges, then fetch.
      #4;
      rst_n      = 1'b1;
      step       = 1'b1;
      bus_in     = 16'h5555;
      dec_uinstr = 16'h0101;
      tick();
      chk("t1_T", {13'd0, T}, 16'd1);
      chk("t1_uinstr", uinstr, 16'h1D00);
      chk("t1_instr_noload", dec_instr, 16'h0000);
      chk("t1_decT", {13'd0, dec_T}, 16'd0);

      bus_in = 16'hA53C;
      tick();
      chk("t2_T", {13'd0, T}, 16'd2);
      chk("t2_instr", dec_instr, 16'hA53C);
      chk("t2_decT", {13'd0, dec_T}, 16'd0);
      chk("t2_uinstr", uinstr, 16'h0101);
      dec_uinstr = 16'h0202;
      #1;
      chk("t2_uinstr_comb", uinstr, 16'h0202);
      dec_uinstr = 16'h0101;

      tick();
      chk("t3_T", {13'd0, T}, 16'd3);
      chk("t3_decT", {13'd0, dec_T}, 16'd1);
      tick();
      chk("t4_T", {13'd0, T}, 16'd4);

      // Stall at T4: bus toggles and ROM asks for an IR load, but nothing may move.
      step       = 1'b0;
      dec_uinstr = 16'h1000;
      for (int i = 0; i < 5; i++) begin
         bus_in = (i % 2 == 0) ? 16'hFFFF : 16'h0F0F;
         #1;
         chk("stall_done", {15'd0, instr_done}, 16'd0);
         tick();
         chk("stall_T", {13'd0, T}, 16'd4);
         chk("stall_instr", dec_instr, 16'hA53C);
      end

      step       = 1'b1;
      dec_uinstr = 16'h0101;
      bus_in     = 16'h0000;
      tick();
      chk("t5_T", {13'd0, T}, 16'd5);

      // IR reload from microcode at T5.
      dec_uinstr = 16'h1001;
      bus_in     = 16'h1234;
      tick();
      chk("t6_T", {13'd0, T}, 16'd6);
      chk("t6_instr", dec_instr, 16'h1234);

      dec_uinstr = 16'h0101;
      tick();
      chk("t7_T", {13'd0, T}, 16'd7);
      chk("t7_decT", {13'd0, dec_T}, 16'd5);
      chk("t7_done", {15'd0, instr_done}, 16'd1);

      // Wrap 7 -> 0.
      tick();
      chk("wrap_T", {13'd0, T}, 16'd0);
      chk("wrap_uinstr", uinstr, 16'h4800);
      chk("wrap_done", {15'd0, instr_done}, 16'd0);
      chk("wrap_instr", dec_instr, 16'h1234);

      // Second instruction: zero ROM word at T3.
      bus_in = 16'hBEEF;
      tick();
      chk("i2_t1_T", {13'd0, T}, 16'd1);
      tick();
      chk("i2_t2_instr", dec_instr, 16'hBEEF);
      tick();
      chk("i2_t3_T", {13'd0, T}, 16'd3);
      dec_uinstr = 16'h0000;
      #1;
      chk("zero_uinstr", uinstr, 16'h0000);
`ifdef UCODE_EARLY_END_EN
      chk("zero_done", {15'd0, instr_done}, 16'd1);
      tick();
      chk("zero_next_T", {13'd0, T}, 16'd0);
`else
      chk("zero_done", {15'd0, instr_done}, 16'd0);
      tick();
      chk("zero_next_T", {13'd0, T}, 16'd4);
`endif

      // Asynchronous reset mid-instruction, checked before the next edge.
      dec_uinstr = 16'h0101;
      tick();
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_T", {13'd0, T}, 16'd0);
      chk("arst_instr", dec_instr, 16'h0000);
      chk("arst_uinstr", uinstr, 16'h4800);
      chk("arst_decT", {13'd0, dec_T}, 16'd0);
      tick();
      chk("arst_hold_T", {13'd0, T}, 16'd0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_T", {13'd0, T}, 16'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
